// File: rtl/sys_bus_pkg.sv
// Shared state encoding and elaboration helpers for sys_bus_ctrl.
// Optional I/O timeout is enabled by defining SYS_BUS_TIMEOUT_EN.
package sys_bus_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } bus_state_e;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Lowest address bit that identifies the I/O window as a whole.
    function automatic int io_win_lsb(input int slot_aw, input int slots);
        return slot_aw + clog2(slots);
    endfunction

endpackage

// File: rtl/reset_sync_stretch.sv
// Synchronises PLL lock and the reset button, then holds cpu_reset_b low
// for RST_STRETCH cycles after every reset source has released.
module reset_sync_stretch
    import sys_bus_pkg::*;
#(
    parameter int RST_STRETCH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    input  logic sw_reset_b,
    output logic cpu_reset_b
);

    localparam int CW = clog2(RST_STRETCH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RST_STRETCH - 1);

    logic [1:0]    lock_q;
    logic [1:0]    sw_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rst_b_q, rst_b_d;
    logic          src;

    assign src = reset | ~lock_q[1] | ~sw_q[1];

    always_comb begin
        cnt_d   = cnt_q;
        rst_b_d = rst_b_q;
        if (src) begin
            cnt_d   = '0;
            rst_b_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            rst_b_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= '0;
            sw_q   <= '0;
        end else begin
            lock_q <= {lock_q[0], pll_lock};
            sw_q   <= {sw_q[0], sw_reset_b};
        end
        cnt_q   <= cnt_d;
        rst_b_q <= rst_b_d;
    end

    assign cpu_reset_b = rst_b_q;

endmodule

// File: rtl/sys_bus_ctrl.sv
// System bus glue: reset sequencing, RAM/IO decode, wait-state insertion and read mux.
// Define SYS_BUS_TIMEOUT_EN to force-complete stalled I/O accesses and flag bus_err.
//
// state   | meaning
// ST_IDLE | CPU running; a new access may be accepted or stalled
// ST_WAIT | CPU stalled until wait count expires and the target is ready
module sys_bus_ctrl
    import sys_bus_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                RAMSIZE     = 12,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'hfe00,
    parameter int                IO_SLOTS    = 4,
    parameter int                IO_SLOT_AW  = 3,
    parameter int                RAM_WAIT    = 0,
    parameter int                IO_WAIT     = 1,
    parameter int                RST_STRETCH = 16,
    parameter int                TIMEOUT     = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pll_lock,
    input  logic                       sw_reset_b,
    output logic                       cpu_reset_b,
    input  logic [ADDR_W-1:0]          cpu_address,
    input  logic                       cpu_vpa,
    input  logic                       cpu_vda,
    output logic                       cpu_clken,
    output logic [DATA_W-1:0]          cpu_din,
    input  logic [DATA_W-1:0]          ram_dout,
    output logic                       ram_cs_b,
    input  logic [IO_SLOTS*DATA_W-1:0] io_dout,
    input  logic [IO_SLOTS-1:0]        io_ready,
    output logic [IO_SLOTS-1:0]        io_cs_b,
    output logic                       bus_err
);

    localparam int SLOT_W  = clog2(IO_SLOTS);
    localparam int WIN_LSB = io_win_lsb(IO_SLOT_AW, IO_SLOTS);

    bus_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        wait_cyc;
    logic [SLOT_W-1:0] slot;
    logic              io_hit, ram_hit, access, ready_ok;
    logic              clken_fsm, tmo_fire;
    logic              unused_addr;

    reset_sync_stretch #(.RST_STRETCH(RST_STRETCH)) u_rst (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .sw_reset_b  (sw_reset_b),
        .cpu_reset_b (cpu_reset_b)
    );

    assign io_hit  = cpu_address[ADDR_W-1:WIN_LSB] == IO_BASE[ADDR_W-1:WIN_LSB];
    assign slot    = cpu_address[IO_SLOT_AW +: SLOT_W];
    assign ram_hit = ~io_hit & ((&cpu_address[ADDR_W-1:RAMSIZE]) | ~(|cpu_address[ADDR_W-1:RAMSIZE]));
    assign ram_cs_b = ~ram_hit;
    assign unused_addr = ^cpu_address[IO_SLOT_AW-1:0];

    always_comb begin
        io_cs_b = '1;
        if (io_hit) io_cs_b[slot] = 1'b0;
    end

    assign access   = (cpu_vpa | cpu_vda) & (io_hit | ram_hit);
    assign ready_ok = io_hit ? io_ready[slot] : 1'b1;
    assign wait_cyc = io_hit ? 4'(IO_WAIT) : 4'(RAM_WAIT);

`ifdef SYS_BUS_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          bus_err_q;

    assign tmo_fire = (state_q == ST_WAIT) & io_hit & ~io_ready[slot] & (tmo_q == TW'(TIMEOUT));

    always_comb begin
        tmo_d = '0;
        if (state_q == ST_WAIT && io_hit && tmo_q != TW'(TIMEOUT)) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            if (tmo_fire) bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_fire       = 1'b0;
    assign bus_err        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clken_fsm = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (access && !(wait_cyc == 4'd0 && ready_ok)) begin
                    clken_fsm = 1'b0;
                    cnt_d     = (wait_cyc == 4'd0) ? 4'd0 : wait_cyc - 4'd1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                clken_fsm = 1'b0;
                if ((cnt_q == 4'd0 && ready_ok) || tmo_fire) begin
                    clken_fsm = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Holding clken high during reset lets the CPU see its own reset edges.
    assign cpu_clken = reset | clken_fsm;

    always_comb begin
        if (tmo_fire)     cpu_din = '1;
        else if (io_hit)  cpu_din = io_dout[slot*DATA_W +: DATA_W];
        else if (ram_hit) cpu_din = ram_dout;
        else              cpu_din = '1;
    end

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Directed bench for sys_bus_ctrl (RAM_WAIT=2, IO_WAIT=1, 16-word I/O slots).
module tb_sys_bus_ctrl;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset, pll_lock, sw_reset_b, cpu_reset_b;
    logic [15:0] cpu_address;
    logic        cpu_vpa, cpu_vda, cpu_clken;
    logic [15:0] cpu_din, ram_dout;
    logic        ram_cs_b;
    logic [63:0] io_dout;
    logic [3:0]  io_ready, io_cs_b;
    logic        bus_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sys_bus_ctrl #(
        .RAM_WAIT   (2),
        .IO_WAIT    (1),
        .IO_SLOT_AW (4),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .sw_reset_b  (sw_reset_b),
        .cpu_reset_b (cpu_reset_b),
        .cpu_address (cpu_address),
        .cpu_vpa     (cpu_vpa),
        .cpu_vda     (cpu_vda),
        .cpu_clken   (cpu_clken),
        .cpu_din     (cpu_din),
        .ram_dout    (ram_dout),
        .ram_cs_b    (ram_cs_b),
        .io_dout     (io_dout),
        .io_ready    (io_ready),
        .io_cs_b     (io_cs_b),
        .bus_err     (bus_err)
    );

    // The address must not move while the CPU is stalled.
    logic        mon_hold = 1'b0;
    logic [15:0] mon_addr = 16'h0;
    always @(posedge clk) begin
        if (reset !== 1'b1 && mon_hold && cpu_address !== mon_addr) begin
            fails++;
            $display("FAIL addr_stable_in_wait: got %h want %h", cpu_address, mon_addr);
        end
        mon_hold = (cpu_clken === 1'b0) && (reset !== 1'b1);
        mon_addr = cpu_address;
    end

    task automatic test_reset();
        reset = 1'b1; pll_lock = 1'b0; sw_reset_b = 1'b1;
        cpu_vpa = 1'b0; cpu_vda = 1'b0; cpu_address = 16'h8000;
        io_ready = 4'b0000; ram_dout = 16'h1234;
        io_dout = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
        repeat (3) @(negedge clk);
        #1;
        tests++; if (cpu_reset_b !== 1'b0) begin fails++; $display("FAIL reset_cpu_reset_b: got %b want 0", cpu_reset_b); end
        tests++; if (cpu_clken !== 1'b1) begin fails++; $display("FAIL reset_clken: got %b want 1", cpu_clken); end
        tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    endtask

    task automatic count_rise(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (cpu_reset_b === 1'b1) begin n = i; break; end
        end
    endtask

    task automatic test_reset_release();
        int n;
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk); #1;
        tests++; if (cpu_reset_b !== 1'b0) begin fails++; $display("FAIL no_lock_held: got %b want 0", cpu_reset_b); end
        @(negedge clk); pll_lock = 1'b1;
        count_rise(n);
        tests++; if (n != 18) begin fails++; $display("FAIL lock_release_delay: got %0d want 18", n); end
        @(negedge clk); pll_lock = 1'b0;
        repeat (4) @(negedge clk); #1;
        tests++; if (cpu_reset_b !== 1'b0) begin fails++; $display("FAIL lock_loss_reset: got %b want 0", cpu_reset_b); end
        @(negedge clk); pll_lock = 1'b1;
        repeat (8) @(negedge clk);
        sw_reset_b = 1'b0;
        @(negedge clk); sw_reset_b = 1'b1;
        count_rise(n);
        tests++; if (n != 18) begin fails++; $display("FAIL sw_pulse_restart: got %0d want 18", n); end
    endtask

    task automatic test_decode();
        logic [15:0] addr [8]   = '{16'h0123, 16'hF123, 16'h8000, 16'hfe08, 16'hfe09, 16'hfe10, 16'hfe30, 16'hfe40};
        logic        e_ram [8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  e_io [8]   = '{4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1101, 4'b0111, 4'b1111};
        logic [15:0] e_din [8]  = '{16'h1234, 16'h1234, 16'hffff, 16'hA000, 16'hA000, 16'hB111, 16'hD333, 16'h1234};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); cpu_address = addr[i]; #1;
            tests++; if (ram_cs_b !== e_ram[i]) begin fails++; $display("FAIL decode_ram_cs %h: got %b want %b", addr[i], ram_cs_b, e_ram[i]); end
            tests++; if (io_cs_b !== e_io[i]) begin fails++; $display("FAIL decode_io_cs %h: got %b want %b", addr[i], io_cs_b, e_io[i]); end
            tests++; if (cpu_din !== e_din[i]) begin fails++; $display("FAIL decode_din %h: got %h want %h", addr[i], cpu_din, e_din[i]); end
            tests++; if (cpu_clken !== 1'b1) begin fails++; $display("FAIL decode_idle_clken %h: got %b want 1", addr[i], cpu_clken); end
        end
    endtask

    task automatic test_ram_wait();
        logic exp;
        @(negedge clk); cpu_address = 16'h0123; cpu_vda = 1'b1; #1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            exp = (i % 3 == 2);
            tests++; if (cpu_clken !== exp) begin fails++; $display("FAIL ram_wait_clken cyc%0d: got %b want %b", i, cpu_clken, exp); end
        end
        @(negedge clk); cpu_vda = 1'b0; cpu_address = 16'hF123; cpu_vpa = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            exp = (i == 2);
            tests++; if (cpu_clken !== exp) begin fails++; $display("FAIL ram_fetch_clken cyc%0d: got %b want %b", i, cpu_clken, exp); end
        end
        @(negedge clk); cpu_vpa = 1'b0; #1;
        tests++; if (cpu_clken !== 1'b1) begin fails++; $display("FAIL ram_idle_after: got %b want 1", cpu_clken); end
    endtask

    task automatic test_io_wait();
        @(negedge clk); cpu_address = 16'hfe10; io_ready = 4'b0000; cpu_vda = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); if (i == 2) io_ready = 4'b1101; #1; end
            tests++; if (cpu_clken !== 1'b0) begin fails++; $display("FAIL io_wait_stall cyc%0d: got %b want 0", i, cpu_clken); end
        end
        @(negedge clk); io_ready = 4'b0010; #1;
        tests++; if (cpu_clken !== 1'b1) begin fails++; $display("FAIL io_ready_release: got %b want 1", cpu_clken); end
        tests++; if (cpu_din !== 16'hB111) begin fails++; $display("FAIL io_ready_din: got %h want b111", cpu_din); end
        @(negedge clk); cpu_vda = 1'b0; io_ready = 4'b0000; #1;
        tests++; if (cpu_clken !== 1'b1) begin fails++; $display("FAIL io_idle_after: got %b want 1", cpu_clken); end
    endtask

    task automatic test_io_min_wait();
        @(negedge clk); cpu_address = 16'hfe20; io_ready = 4'b0100; cpu_vda = 1'b1; #1;
        tests++; if (cpu_clken !== 1'b0) begin fails++; $display("FAIL io_min_wait_first: got %b want 0", cpu_clken); end
        @(negedge clk); #1;
        tests++; if (cpu_clken !== 1'b1) begin fails++; $display("FAIL io_min_wait_done: got %b want 1", cpu_clken); end
        tests++; if (cpu_din !== 16'hC222) begin fails++; $display("FAIL io_min_wait_din: got %h want c222", cpu_din); end
        @(negedge clk); cpu_vda = 1'b0; io_ready = 4'b0000;
    endtask

    task automatic test_timeout();
        int n;
        @(negedge clk); cpu_address = 16'hfe30; io_ready = 4'b0000; cpu_vda = 1'b1; #1;
`ifdef SYS_BUS_TIMEOUT_EN
        begin
            logic        done;
            logic [15:0] din;
            logic        err_now;
            n = 0; done = 1'b0; din = 16'h0; err_now = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if (i > 0) begin @(negedge clk); #1; end
                if (cpu_clken === 1'b1) begin done = 1'b1; din = cpu_din; err_now = bus_err; break; end
                n++;
            end
            tests++; if (done !== 1'b1) begin fails++; $display("FAIL timeout_completes: got %b want 1", done); end
            tests++; if (n != TIMEOUT + 1) begin fails++; $display("FAIL timeout_stall_len: got %0d want %0d", n, TIMEOUT + 1); end
            tests++; if (din !== 16'hffff) begin fails++; $display("FAIL timeout_din: got %h want ffff", din); end
            tests++; if (err_now !== 1'b0) begin fails++; $display("FAIL timeout_err_early: got %b want 0", err_now); end
            @(negedge clk); cpu_vda = 1'b0; #1;
            tests++; if (bus_err !== 1'b1) begin fails++; $display("FAIL timeout_err_set: got %b want 1", bus_err); end
            repeat (3) @(negedge clk); #1;
            tests++; if (bus_err !== 1'b1) begin fails++; $display("FAIL timeout_err_sticky: got %b want 1", bus_err); end
        end
`else
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            if (cpu_clken === 1'b0) n++;
        end
        tests++; if (n != 300) begin fails++; $display("FAIL no_timeout_stall: got %0d want 300", n); end
        tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL no_timeout_err: got %b want 0", bus_err); end
        @(negedge clk); io_ready = 4'b1000; #1;
        tests++; if (cpu_clken !== 1'b1) begin fails++; $display("FAIL late_ready_release: got %b want 1", cpu_clken); end
        tests++; if (cpu_din !== 16'hD333) begin fails++; $display("FAIL late_ready_din: got %h want d333", cpu_din); end
        @(negedge clk); cpu_vda = 1'b0; io_ready = 4'b0000;
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic exp;
        @(negedge clk); cpu_address = 16'hfe30; io_ready = 4'b0000; cpu_vda = 1'b1;
        repeat (2) @(negedge clk); #1;
        tests++; if (cpu_clken !== 1'b0) begin fails++; $display("FAIL mid_wait_stalled: got %b want 0", cpu_clken); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        tests++; if (cpu_clken !== 1'b1) begin fails++; $display("FAIL mid_wait_reset_clken: got %b want 1", cpu_clken); end
        tests++; if (cpu_reset_b !== 1'b0) begin fails++; $display("FAIL mid_wait_reset_cpu_rst: got %b want 0", cpu_reset_b); end
        tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL mid_wait_reset_err: got %b want 0", bus_err); end
        @(negedge clk); reset = 1'b0; cpu_vda = 1'b0; cpu_address = 16'h0123; #1;
        tests++; if (cpu_clken !== 1'b1) begin fails++; $display("FAIL post_reset_idle: got %b want 1", cpu_clken); end
        @(negedge clk); cpu_vda = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            exp = (i == 2);
            tests++; if (cpu_clken !== exp) begin fails++; $display("FAIL post_reset_ram cyc%0d: got %b want %b", i, cpu_clken, exp); end
        end
        @(negedge clk); cpu_vda = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_decode();
        test_ram_wait();
        test_io_wait();
        test_io_min_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

endmodule
